i2c_codec_cfg_seq: RTL and testbench



---
 rtl/i2c_codec_cfg_seq.sv | 137 +++++++++++++
 tb/tb_i2c_codec_cfg_seq.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_cfg_seq.sv
// i2c_codec_cfg_seq: walks the WM8731 mic-path register table through i2c_master's write handshake.
// Define I2C_SEQ_RETRY_EN to resend a NACKed entry up to MAX_RETRIES extra times before failing.
module i2c_codec_cfg_seq #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h1A,
    parameter int         NUM_REGS    = 7,
    parameter int         GAP_CYCLES  = 4,
    parameter int         MAX_RETRIES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [2:0] fail_index,
    output logic [6:0] slav_addr,
    output logic       read_not_write,
    output logic [7:0] reg_addr,
    output logic [7:0] write_data,
    output logic       write_valid,
    input  logic       write_ready,
    input  logic       error
);
    localparam int              GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [2:0]      LAST  = 3'(NUM_REGS - 1);
    localparam logic [GW-1:0]   GLAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_DONE, CHECK, GAP, DONE, FAIL} state_t;

    state_t        state;
    logic [2:0]    index;
    logic [2:0]    next_index;
    logic [GW-1:0] gcnt;
    logic          err_q;
    logic          wv_q;
    logic          exhausted;

    function automatic logic [15:0] entry(input logic [2:0] i);
        case (i)
            3'd0:    return 16'h1E00;
            3'd1:    return 16'h0C00;
            3'd2:    return 16'h0815;
            3'd3:    return 16'h0A00;
            3'd4:    return 16'h0E02;
            3'd5:    return 16'h1000;
            default: return 16'h1201;
        endcase
    endfunction

    assign slav_addr      = SLAVE_ADDR;
    assign read_not_write = 1'b0;
    // Gated so a reset landing mid-SEND can never complete a handshake with the master
    assign write_valid    = wv_q && !reset;
    assign next_index     = err_q ? index : index + 3'd1;

`ifdef I2C_SEQ_RETRY_EN
    localparam int            RW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRIES);
    logic [RW-1:0] retry;
    assign exhausted = (retry == RMAX);
    always_ff @(posedge clk) begin
        if (reset || state == IDLE || state == DONE || state == FAIL)
            retry <= '0;
        else if (state == CHECK && !(err_q && exhausted))
            retry <= err_q ? retry + 1'b1 : '0;
    end
`else
    assign exhausted = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_index <= 3'd0;
            wv_q       <= 1'b0;
            reg_addr   <= 8'h00;
            write_data <= 8'h00;
            index      <= 3'd0;
            gcnt       <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, FAIL: if (start) begin
                    state                  <= SEND;
                    index                  <= 3'd0;
                    busy                   <= 1'b1;
                    done                   <= 1'b0;
                    fail                   <= 1'b0;
                    wv_q                   <= 1'b1;
                    {reg_addr, write_data} <= entry(3'd0);
                end
                SEND: if (write_ready) begin
                    state <= WAIT_DONE;
                    wv_q  <= 1'b0;
                end
                // error is only valid on the first cycle write_ready returns, so capture it here
                WAIT_DONE: if (write_ready) begin
                    state <= CHECK;
                    err_q <= error;
                end
                CHECK: begin
                    if (!err_q && index == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (err_q && exhausted) begin
                        state      <= FAIL;
                        busy       <= 1'b0;
                        fail       <= 1'b1;
                        fail_index <= index;
                    end else begin
                        index <= next_index;
                        if (GAP_CYCLES == 0) begin
                            state                  <= SEND;
                            wv_q                   <= 1'b1;
                            {reg_addr, write_data} <= entry(next_index);
                        end else begin
                            state <= GAP;
                            gcnt  <= '0;
                        end
                    end
                end
                GAP: if (gcnt == GLAST) begin
                    state                  <= SEND;
                    wv_q                   <= 1'b1;
                    {reg_addr, write_data} <= entry(index);
                end else begin
                    gcnt <= gcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_codec_cfg_seq.sv
// tb_i2c_codec_cfg_seq: randomized bench with a behavioural i2c_master stand-in and a table-level reference model.
module tb_i2c_codec_cfg_seq;
    localparam int GAP  = 4;
    localparam int MAXR = 3;
    localparam int N    = 7;
    localparam int STALL_SNAPS = 11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       write_ready;
    logic       error;
    logic       busy, done, fail, read_not_write, write_valid;
    logic [2:0] fail_index;
    logic [6:0] slav_addr;
    logic [7:0] reg_addr, write_data;

    i2c_codec_cfg_seq dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .fail(fail),
        .fail_index(fail_index), .slav_addr(slav_addr), .read_not_write(read_not_write),
        .reg_addr(reg_addr), .write_data(write_data), .write_valid(write_valid),
        .write_ready(write_ready), .error(error)
    );

    always #5 clk = ~clk;

    logic [15:0] tbl [7] = '{16'h1E00, 16'h0C00, 16'h0815, 16'h0A00, 16'h0E02, 16'h1000, 16'h1201};

    int          checks = 0;
    int          failures = 0;
    logic [15:0] hs_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] snap_q[$];
    int          gaps[$];
    int          nack_left[7];
    int          xfer_len = 6;
    bit          stall_mode = 0;
    bit          pend = 0;
    bit          exp_done;
    int          exp_fidx;

    // Master stand-in: accepts on write_valid&&write_ready, drops ready for xfer_len cycles with
    // junk on error, then returns ready with the ACK/NACK result valid for that one cycle only.
    initial begin
        bit hs = 0, prev_wv = 0, pnack = 0;
        int busy_left = 0, scnt = 0, cyc = 0, t_ret = 0;
        write_ready = 1'b1;
        error = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (hs) begin
                hs = 0;
                write_ready = 1'b0;
                error = 1'($urandom_range(0, 1));
                busy_left = xfer_len;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    write_ready = 1'b1;
                    error = pnack;
                    t_ret = cyc;
                    pend = 1;
                end else error = 1'($urandom_range(0, 1));
            end else begin
                error = 1'b0;
                if (stall_mode) begin
                    if (!write_valid) begin
                        write_ready = 1'b0;
                        scnt = 0;
                    end else if (!write_ready) begin
                        snap_q.push_back({reg_addr, write_data});
                        scnt++;
                        if (scnt == STALL_SNAPS) write_ready = 1'b1;
                    end
                end else write_ready = 1'b1;
            end
            if (write_valid === 1'b1 && !prev_wv && pend) begin
                gaps.push_back(cyc - t_ret);
                pend = 0;
            end
            prev_wv = (write_valid === 1'b1);
            if (write_valid === 1'b1 && write_ready) begin
                hs = 1;
                hs_q.push_back({reg_addr, write_data});
                pnack = 0;
                for (int i = 0; i < N; i++)
                    if (tbl[i] == {reg_addr, write_data} && nack_left[i] > 0) begin
                        nack_left[i]--;
                        pnack = 1;
                    end
            end
        end
    end

    // Expected write list: entry i is attempted min(nacks+1, limit) times; running out of attempts fails there.
    task automatic build_exp(input int nk[7]);
        int lim, att;
`ifdef I2C_SEQ_RETRY_EN
        lim = MAXR + 1;
`else
        lim = 1;
`endif
        exp_q.delete();
        exp_done = 1;
        exp_fidx = 0;
        for (int i = 0; i < N; i++) begin
            att = (nk[i] < lim) ? nk[i] + 1 : lim;
            repeat (att) exp_q.push_back(tbl[i]);
            if (nk[i] >= lim) begin
                exp_done = 0;
                exp_fidx = i;
                break;
            end
        end
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(output bit to);
        to = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #2;
            if (done || fail) begin
                to = 0;
                break;
            end
        end
    endtask

    task automatic wait_hs(input int n, output bit to);
        to = 1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #2;
            if (hs_q.size() >= n) begin
                to = 0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (fail !== 1'b0) begin failures++; $display("FAIL reset_fail got=%b exp=0", fail); end
        checks++; if (write_valid !== 1'b0) begin failures++; $display("FAIL reset_wv got=%b exp=0", write_valid); end
        checks++; if (fail_index !== 3'd0) begin failures++; $display("FAIL reset_fidx got=%0d exp=0", fail_index); end
        checks++; if ({reg_addr, write_data} !== 16'h0000) begin failures++; $display("FAIL reset_bytes got=%h exp=0000", {reg_addr, write_data}); end
        checks++; if (slav_addr !== 7'h1A) begin failures++; $display("FAIL slav_addr got=%h exp=1a", slav_addr); end
        checks++; if (read_not_write !== 1'b0) begin failures++; $display("FAIL rnw got=%b exp=0", read_not_write); end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        checks++; if (busy !== 1'b0 || write_valid !== 1'b0) begin failures++; $display("FAIL idle_quiet got=%b%b exp=00", busy, write_valid); end
    endtask

    task automatic test_all_ack;
        int zero[7] = '{default: 0};
        bit to;
        nack_left = zero;
        build_exp(zero);
        xfer_len = $urandom_range(4, 12);
        hs_q.delete();
        gaps.delete();
        pend = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        checks++; if (write_valid !== 1'b1) begin failures++; $display("FAIL start_latency wv=%b exp=1", write_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%b exp=1", busy); end
        wait_end(to);
        checks++; if (to) begin failures++; $display("FAIL all_ack_timeout done=%b exp=1", done); end
        checks++; if (hs_q.size() != exp_q.size()) begin failures++; $display("FAIL all_ack_count got=%0d exp=%0d", hs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
            checks++; if (hs_q[i] !== exp_q[i]) begin failures++; $display("FAIL all_ack_write[%0d] got=%h exp=%h", i, hs_q[i], exp_q[i]); end
        end
        checks++; if (gaps.size() != N - 1) begin failures++; $display("FAIL gap_count got=%0d exp=%0d", gaps.size(), N - 1); end
        // return cycle + CHECK cycle + GAP idle cycles before write_valid rises again
        foreach (gaps[i]) begin
            checks++; if (gaps[i] != GAP + 2) begin failures++; $display("FAIL gap[%0d] got=%0d exp=%0d", i, gaps[i], GAP + 2); end
        end
        checks++; if ({done, busy, fail} !== 3'b100) begin failures++; $display("FAIL all_ack_end dbf=%b exp=100", {done, busy, fail}); end
    endtask

    task automatic test_stall;
        int zero[7] = '{default: 0};
        bit to;
        nack_left = zero;
        xfer_len = $urandom_range(2, 8);
        hs_q.delete();
        snap_q.delete();
        @(negedge clk);
        stall_mode = 1;
        pulse_start();
        wait_end(to);
        stall_mode = 0;
        checks++; if (to) begin failures++; $display("FAIL stall_timeout done=%b exp=1", done); end
        checks++; if (hs_q.size() != N) begin failures++; $display("FAIL stall_hs_count got=%0d exp=%0d", hs_q.size(), N); end
        for (int i = 0; i < N && i < hs_q.size(); i++) begin
            checks++; if (hs_q[i] !== tbl[i]) begin failures++; $display("FAIL stall_write[%0d] got=%h exp=%h", i, hs_q[i], tbl[i]); end
        end
        checks++; if (snap_q.size() != N * STALL_SNAPS) begin failures++; $display("FAIL stall_snaps got=%0d exp=%0d", snap_q.size(), N * STALL_SNAPS); end
        foreach (snap_q[k]) begin
            checks++; if (snap_q[k] !== tbl[k / STALL_SNAPS]) begin failures++; $display("FAIL stall_hold[%0d] got=%h exp=%h", k, snap_q[k], tbl[k / STALL_SNAPS]); end
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL stall_done got=%b exp=1", done); end
    endtask

    task automatic test_nack;
        int nk[7];
        bit to;
        for (int s = 0; s < 7; s++) begin
            nk = '{default: 0};
            if (s == 0) nk[2] = 1;
            else if (s == 1) nk[4] = 99;
            else for (int i = 0; i < N; i++) nk[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            nack_left = nk;
            build_exp(nk);
            xfer_len = $urandom_range(2, 10);
            hs_q.delete();
            pulse_start();
            wait_end(to);
            checks++; if (to) begin failures++; $display("FAIL nack%0d_timeout done=%b fail=%b", s, done, fail); end
            checks++; if (hs_q.size() != exp_q.size()) begin failures++; $display("FAIL nack%0d_count got=%0d exp=%0d", s, hs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
                checks++; if (hs_q[i] !== exp_q[i]) begin failures++; $display("FAIL nack%0d_write[%0d] got=%h exp=%h", s, i, hs_q[i], exp_q[i]); end
            end
            checks++; if ({done, fail, busy} !== {exp_done, !exp_done, 1'b0}) begin failures++; $display("FAIL nack%0d_end dfb=%b exp=%b%b0", s, {done, fail, busy}, exp_done, !exp_done); end
            if (!exp_done) begin
                checks++; if (fail_index !== 3'(exp_fidx)) begin failures++; $display("FAIL nack%0d_fidx got=%0d exp=%0d", s, fail_index, exp_fidx); end
            end
        end
    endtask

    task automatic test_reset_mid;
        int nk[7] = '{default: 0};
        bit to;
        nk[3] = 1;
        nack_left = nk;
        xfer_len = 12;
        hs_q.delete();
        pulse_start();
        wait_hs(4, to);
        checks++; if (to) begin failures++; $display("FAIL rmid_reach_entry3 got=%0d exp=4", hs_q.size()); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #2;
        checks++; if (write_valid !== 1'b0) begin failures++; $display("FAIL rmid_wv_in_reset got=%b exp=0", write_valid); end
        @(negedge clk);
        #2;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        @(negedge clk);
        reset = 1'b0;
        hs_q.delete();
        pulse_start();
        #2;
        checks++; if ({write_valid, write_ready} !== 2'b10) begin failures++; $display("FAIL rmid_wait_ready got=%b exp=10", {write_valid, write_ready}); end
        wait_end(to);
        checks++; if (to) begin failures++; $display("FAIL rmid_timeout done=%b exp=1", done); end
        checks++; if (hs_q.size() != N) begin failures++; $display("FAIL rmid_count got=%0d exp=%0d", hs_q.size(), N); end
        for (int i = 0; i < N && i < hs_q.size(); i++) begin
            checks++; if (hs_q[i] !== tbl[i]) begin failures++; $display("FAIL rmid_write[%0d] got=%h exp=%h", i, hs_q[i], tbl[i]); end
        end
        checks++; if ({done, fail} !== 2'b10) begin failures++; $display("FAIL rmid_end df=%b exp=10", {done, fail}); end
    endtask

    task automatic test_back_to_back;
        int zero[7] = '{default: 0};
        bit to;
        nack_left = zero;
        xfer_len = $urandom_range(3, 9);
        hs_q.delete();
        pulse_start();
        wait_hs(3, to);
        checks++; if (to) begin failures++; $display("FAIL b2b_reach got=%0d exp=3", hs_q.size()); end
        pulse_start();
        wait_end(to);
        checks++; if (to) begin failures++; $display("FAIL b2b_timeout done=%b exp=1", done); end
        checks++; if (hs_q.size() != N) begin failures++; $display("FAIL b2b_busy_start_count got=%0d exp=%0d", hs_q.size(), N); end
        for (int i = 0; i < N && i < hs_q.size(); i++) begin
            checks++; if (hs_q[i] !== tbl[i]) begin failures++; $display("FAIL b2b_first[%0d] got=%h exp=%h", i, hs_q[i], tbl[i]); end
        end
        hs_q.delete();
        pulse_start();
        #2;
        checks++; if ({done, busy} !== 2'b01) begin failures++; $display("FAIL b2b_restart db=%b exp=01", {done, busy}); end
        wait_end(to);
        checks++; if (to) begin failures++; $display("FAIL b2b_timeout2 done=%b exp=1", done); end
        checks++; if (hs_q.size() != N) begin failures++; $display("FAIL b2b_replay_count got=%0d exp=%0d", hs_q.size(), N); end
        for (int i = 0; i < N && i < hs_q.size(); i++) begin
            checks++; if (hs_q[i] !== tbl[i]) begin failures++; $display("FAIL b2b_replay[%0d] got=%h exp=%h", i, hs_q[i], tbl[i]); end
        end
        checks++; if ({done, busy, fail} !== 3'b100) begin failures++; $display("FAIL b2b_end dbf=%b exp=100", {done, busy, fail}); end
    endtask

    initial begin
        nack_left = '{default: 0};
        test_reset();
        test_all_ack();
        test_stall();
        test_nack();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
